upstream_out_credit_sched: RTL and testbench

Token-credit scheduler and sequencer for the upstream output link. Two 64-bit requesters share the link: req0 is the core path and req1 is the maintenance/loopback path. Grants are round-robin, gated by link credits. Each granted word is sequenced as 4 beats onto the two 8-bit io channels. Credits are consumed one per word and returned by io_token pulses from the downstream receiver.

---
 rtl/upstream_out_credit_sched.sv | 183 ++++++++++++++++++
 tb/tb_upstream_out_credit_sched.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/upstream_out_credit_sched.sv
// rtl/upstream_out_credit_sched.sv - credit-gated round-robin scheduler and 4-beat sequencer for the upstream output link
//
// Two 64-bit requesters share the link: req0 is the core path, req1 the
// maintenance/loopback path. A word is granted only when a link credit is
// available. Each granted word then goes out as four 16-bit beats split
// across two 8-bit io channels. Credits come back as rising edges on io_token.
//
// Parameters:
//   CREDITS  credits loaded at reset (max words in flight), 1..255
//   CW       credit counter width, 2**CW > CREDITS
//
// Ports:
//   clk, rst_n                      link clock, asynchronous active-low reset
//   req0_valid/req0_data/req0_ready core requester handshake (ready is combinational)
//   req1_valid/req1_data/req1_ready maintenance requester handshake
//   io_token                        credit return, one credit per rising edge
//   io_valid_out                    beat valid on the io channels
//   io_data_out_ch0/ch1             low/high byte of the current 16-bit beat
//   credit_cnt                      credits currently available
//   credit_err                      sticky flag: credit returned beyond CREDITS
//   busy                            a word is in flight on the link
//   last_grant                      index of the most recently granted requester
//   io_parity_out                   odd parity of the beat (only with UPSTREAM_SCHED_PARITY_EN)
//
// Optional feature macro: UPSTREAM_SCHED_PARITY_EN

module upstream_out_credit_sched #(
  parameter int CREDITS = 16,
  parameter int CW      = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  input  logic [63:0]   req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [63:0]   req1_data,
  output logic          req1_ready,
  input  logic          io_token,
  output logic          io_valid_out,
  output logic [7:0]    io_data_out_ch0,
  output logic [7:0]    io_data_out_ch1,
  output logic [CW-1:0] credit_cnt,
  output logic          credit_err,
  output logic          busy,
  output logic          last_grant
`ifdef UPSTREAM_SCHED_PARITY_EN
  ,
  output logic          io_parity_out
`endif
);

  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t      state;
  logic [1:0]  beat;       // index of the beat currently on the pins
  logic [47:0] word_q;     // beats 1..3 of the word in flight; beat 0 goes out at grant
  logic        tok_q;      // io_token delayed one cycle for edge detection

  logic        tok_edge;
  logic        grant_opp;
  logic        credit_ok;
  logic        pick1;
  logic        grant;
  logic [63:0] grant_data;
  logic [15:0] next_beat;

  // A level held high on io_token returns only one credit.
  assign tok_edge  = io_token & ~tok_q;

  // The last beat of a word is also a grant slot so back-to-back words have no bubble.
  assign grant_opp = (state == IDLE) || (beat == 2'd3);

  // A credit returning this very cycle may be spent immediately.
  assign credit_ok = (credit_cnt != '0) || tok_edge;

  // Round-robin: with both requesting, the one not granted last time wins.
  always_comb begin
    pick1 = 1'b0;
    if (req0_valid && req1_valid) begin
      pick1 = ~last_grant;
    end else begin
      pick1 = req1_valid;
    end
  end

  assign grant      = grant_opp && credit_ok && (req0_valid || req1_valid);
  assign req0_ready = grant && !pick1;
  assign req1_ready = grant &&  pick1;
  assign grant_data = pick1 ? req1_data : req0_data;

  // Beat to load after the one currently on the pins.
  always_comb begin
    next_beat = 16'h0000;
    case (beat)
      2'd0:    next_beat = word_q[15:0];
      2'd1:    next_beat = word_q[31:16];
      default: next_beat = word_q[47:32];
    endcase
  end

  // Sequencer FSM: all link-facing outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      beat            <= 2'd0;
      word_q          <= '0;
      tok_q           <= 1'b0;
      io_valid_out    <= 1'b0;
      io_data_out_ch0 <= 8'h00;
      io_data_out_ch1 <= 8'h00;
      busy            <= 1'b0;
      last_grant      <= 1'b1;
`ifdef UPSTREAM_SCHED_PARITY_EN
      io_parity_out   <= 1'b1;
`endif
    end else begin
      tok_q <= io_token;
      if (grant) begin
        state           <= SEND;
        beat            <= 2'd0;
        word_q          <= grant_data[63:16];
        io_valid_out    <= 1'b1;
        busy            <= 1'b1;
        io_data_out_ch0 <= grant_data[7:0];
        io_data_out_ch1 <= grant_data[15:8];
        last_grant      <= pick1;
`ifdef UPSTREAM_SCHED_PARITY_EN
        io_parity_out   <= ~^grant_data[15:0];
`endif
      end else begin
        case (state)
          SEND: begin
            if (beat == 2'd3) begin
              // Word finished with nothing granted: go quiet, data pins hold.
              state         <= IDLE;
              beat          <= 2'd0;
              io_valid_out  <= 1'b0;
              busy          <= 1'b0;
`ifdef UPSTREAM_SCHED_PARITY_EN
              io_parity_out <= 1'b1;
`endif
            end else begin
              beat            <= beat + 2'd1;
              io_data_out_ch0 <= next_beat[7:0];
              io_data_out_ch1 <= next_beat[15:8];
`ifdef UPSTREAM_SCHED_PARITY_EN
              io_parity_out   <= ~^next_beat;
`endif
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // Credit accounting: a spend and a return in the same cycle cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_cnt <= CRED_MAX;
      credit_err <= 1'b0;
    end else begin
      if (grant && !tok_edge) begin
        credit_cnt <= credit_cnt - CW'(1);
      end else if (tok_edge && !grant) begin
        if (credit_cnt == CRED_MAX) begin
          credit_err <= 1'b1;
        end else begin
          credit_cnt <= credit_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_upstream_out_credit_sched.sv
// tb/tb_upstream_out_credit_sched.sv - self-checking bench for upstream_out_credit_sched
module tb_upstream_out_credit_sched;

  localparam int CREDITS = 16;
  localparam int CW      = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req0_valid = 1'b0;
  logic [63:0]   req0_data = '0;
  logic          req0_ready;
  logic          req1_valid = 1'b0;
  logic [63:0]   req1_data = '0;
  logic          req1_ready;
  logic          io_token = 1'b0;
  logic          io_valid_out;
  logic [7:0]    io_data_out_ch0;
  logic [7:0]    io_data_out_ch1;
  logic [CW-1:0] credit_cnt;
  logic          credit_err;
  logic          busy;
  logic          last_grant;
`ifdef UPSTREAM_SCHED_PARITY_EN
  logic          io_parity_out;
`endif

  always #5 clk = ~clk;

  upstream_out_credit_sched #(.CREDITS(CREDITS), .CW(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req0_valid      (req0_valid),
    .req0_data       (req0_data),
    .req0_ready      (req0_ready),
    .req1_valid      (req1_valid),
    .req1_data       (req1_data),
    .req1_ready      (req1_ready),
    .io_token        (io_token),
    .io_valid_out    (io_valid_out),
    .io_data_out_ch0 (io_data_out_ch0),
    .io_data_out_ch1 (io_data_out_ch1),
    .credit_cnt      (credit_cnt),
    .credit_err      (credit_err),
    .busy            (busy),
    .last_grant      (last_grant)
`ifdef UPSTREAM_SCHED_PARITY_EN
    ,
    .io_parity_out   (io_parity_out)
`endif
  );

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Words are modelled as a queue of beats still waiting for the pins; a new
  // word may only be taken when that queue is empty.
  int          m_cnt;
  bit          m_err;
  bit          m_last;
  bit          m_tokp;
  bit          m_valid;
  bit          m_par;
  logic [15:0] m_pins;
  logic [15:0] pend[$];
  bit          e_edge, e_grant, e_pick1;
  logic [63:0] e_word;

  function automatic void model_reset();
    m_cnt   = CREDITS;
    m_err   = 1'b0;
    m_last  = 1'b1;
    m_tokp  = 1'b0;
    m_valid = 1'b0;
    m_par   = 1'b1;
    m_pins  = 16'h0000;
    pend.delete();
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset();
      chk("rst_valid", io_valid_out, 0);
      chk("rst_cnt", credit_cnt, CREDITS);
      chk("rst_err", credit_err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_last", last_grant, 1);
      chk("rst_data", {io_data_out_ch1, io_data_out_ch0}, 0);
    end else begin
      chk("m_valid", io_valid_out, m_valid);
      chk("m_busy", busy, m_valid);
      chk("m_data", {io_data_out_ch1, io_data_out_ch0}, m_pins);
      chk("m_cnt", credit_cnt, m_cnt);
      chk("m_err", credit_err, m_err);
      chk("m_last", last_grant, m_last);
`ifdef UPSTREAM_SCHED_PARITY_EN
      chk("m_par", io_parity_out, m_par);
`endif
      e_edge  = io_token && !m_tokp;
      e_pick1 = (req0_valid && req1_valid) ? !m_last : req1_valid;
      e_grant = (pend.size() == 0) && (m_cnt > 0 || e_edge) && (req0_valid || req1_valid);
      chk("m_ready0", req0_ready, e_grant && !e_pick1);
      chk("m_ready1", req1_ready, e_grant && e_pick1);
      if (e_grant) begin
        e_word = e_pick1 ? req1_data : req0_data;
        pend.push_back(e_word[31:16]);
        pend.push_back(e_word[47:32]);
        pend.push_back(e_word[63:48]);
        m_pins  = e_word[15:0];
        m_valid = 1'b1;
        m_par   = ~^m_pins;
        m_last  = e_pick1;
      end else if (pend.size() > 0) begin
        m_pins  = pend.pop_front();
        m_valid = 1'b1;
        m_par   = ~^m_pins;
      end else begin
        m_valid = 1'b0;
        m_par   = 1'b1;
      end
      if (e_grant && !e_edge) m_cnt = m_cnt - 1;
      else if (e_edge && !e_grant) begin
        if (m_cnt == CREDITS) m_err = 1'b1;
        else m_cnt = m_cnt + 1;
      end
      m_tokp = io_token;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Hold req0 valid until n words are accepted or the cycle budget runs out.
  task automatic push_words(input int n, input int budget, output int got);
    logic acc;
    got = 0;
    req0_valid = 1'b1;
    req0_data  = {$urandom, $urandom};
    for (int c = 0; c < budget && got < n; c++) begin
      @(negedge clk);
      acc = req0_ready;
      if (acc) got++;
      tick();
      if (acc) req0_data = {$urandom, $urandom};
    end
    req0_valid = 1'b0;
  endtask

  logic [15:0] exp1 [4];
  int          got;
  int          ng;
  logic [3:0]  order;
  int          run, max_run;
  logic        a0, a1;
  int          tok_mod;

  initial begin
    exp1[0] = 16'hCDEF; exp1[1] = 16'h89AB; exp1[2] = 16'h4567; exp1[3] = 16'h0123;
    #2 rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;

    // Single word
    req0_data  = 64'h0123_4567_89AB_CDEF;
    req0_valid = 1'b1;
    @(negedge clk);
    chk("t1_ready", req0_ready, 1);
    chk("t1_cnt_pre", credit_cnt, 16);
    tick();
    req0_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t1_beat", {io_valid_out, io_data_out_ch1, io_data_out_ch0}, {1'b1, exp1[k]});
    end
    @(negedge clk);
    chk("t1_idle", io_valid_out, 0);
    chk("t1_cnt_post", credit_cnt, 15);

    // Fairness and no bubbles
    do_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = {$urandom, $urandom}; req1_data = {$urandom, $urandom};
    ng = 0; order = '0; run = 0; max_run = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      @(negedge clk);
      a0 = req0_ready; a1 = req1_ready;
      if (io_valid_out) begin run++; if (run > max_run) max_run = run; end else run = 0;
      if (a0) begin order = {order[2:0], 1'b0}; ng++; end
      if (a1) begin order = {order[2:0], 1'b1}; ng++; end
      tick();
      if (ng >= 4) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end else begin
        if (a0) req0_data = {$urandom, $urandom};
        if (a1) req1_data = {$urandom, $urandom};
      end
    end
    repeat (6) begin
      @(negedge clk);
      if (io_valid_out) begin run++; if (run > max_run) max_run = run; end else run = 0;
    end
    chk("fair_ngrants", ng, 4);
    chk("fair_order", order, 4'b0101);
    chk("fair_run", max_run, 16);

    // Credit exhaustion: 17 words offered, no tokens
    do_reset();
    push_words(17, 100, got);
    chk("exh_words", got, 16);
    req0_valid = 1'b1;
    @(negedge clk);
    chk("exh_cnt0", credit_cnt, 0);
    chk("exh_noready", req0_ready, 0);
    tick();
    io_token = 1'b1;
    @(negedge clk);
    chk("exh_tok_grant", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    io_token = 1'b0;
    @(negedge clk);
    chk("exh_cnt_after", credit_cnt, 0);

    // Simultaneous consume/return at 5, then a held token
    do_reset();
    push_words(11, 80, got);
    chk("sim_words", got, 11);
    repeat (5) @(negedge clk);
    chk("sim_cnt5", credit_cnt, 5);
    tick();
    req0_valid = 1'b1;
    io_token = 1'b1;
    @(negedge clk);
    chk("sim_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    io_token = 1'b0;
    @(negedge clk);
    chk("sim_cnt_same", credit_cnt, 5);
    tick();
    io_token = 1'b1;
    repeat (3) tick();
    io_token = 1'b0;
    @(negedge clk);
    chk("held_tok_once", credit_cnt, 6);

    // Overflow
    do_reset();
    tick();
    io_token = 1'b1;
    tick();
    io_token = 1'b0;
    @(negedge clk);
    chk("ovf_cnt", credit_cnt, 16);
    chk("ovf_err", credit_err, 1);
    repeat (5) tick();
    @(negedge clk);
    chk("ovf_sticky", credit_err, 1);
    do_reset();
    @(negedge clk);
    chk("ovf_cleared", credit_err, 0);

    // Reset during beat 1
    tick();
    req0_data = {$urandom, $urandom};
    req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("rmw_valid", io_valid_out, 0);
    chk("rmw_cnt", credit_cnt, 16);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("rmw_quiet", io_valid_out, 0);
    end

    // Randomized traffic with tokens and occasional resets
    do_reset();
    tok_mod = 8;
    a0 = 1'b0; a1 = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      a0 = req0_ready; a1 = req1_ready;
      tick();
      if (c % 500 == 0) tok_mod = ($urandom % 2 == 0) ? 3 : 9;
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom % 700 == 0) rst_n = 1'b0;
      if (!req0_valid || a0) begin
        req0_valid = ($urandom % 3) != 0;
        req0_data  = {$urandom, $urandom};
      end
      if (!req1_valid || a1) begin
        req1_valid = ($urandom % 3) == 0;
        req1_data  = {$urandom, $urandom};
      end
      io_token = ($urandom % tok_mod) == 0;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; io_token = 1'b0; rst_n = 1'b1;
    repeat (8) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, vectors %0d errors %0d", vectors, errors);
    $fatal(1);
  end

endmodule
